// File: rtl/button_press_decoder.sv
// Button gesture classifier: turns debounced press/release pulses into
// short, double, long and auto-repeat event pulses plus a held level.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | button up, no gesture pending
// HELD   | first press in progress, timing towards long press
// LHELD  | long press reached, emitting auto-repeat pulses
// WAIT2  | first press released, waiting for a second press
// HELD2  | second press in progress (double unless held long)
module button_press_decoder #(
    parameter int CNT_WIDTH    = 26,
    parameter int LONG_TICKS   = 50_000_000,
    parameter int REPEAT_TICKS = 12_500_000,
    parameter int DBL_TICKS    = 15_000_000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic down_i,
    input  logic up_i,
    output logic short_o,
    output logic double_o,
    output logic long_o,
    output logic repeat_o,
    output logic held_o
);

    if (LONG_TICKS < 2 || REPEAT_TICKS < 2 || DBL_TICKS < 2 ||
        (LONG_TICKS >> CNT_WIDTH) != 0 || (REPEAT_TICKS >> CNT_WIDTH) != 0 ||
        (DBL_TICKS >> CNT_WIDTH) != 0) begin : g_param_check
        $error("button_press_decoder: tick parameters must be >= 2 and fit in CNT_WIDTH");
    end

    // States entered on a sampled press/release count that sampling cycle as
    // their first tick, so they stop one count earlier than LHELD, whose entry
    // and repeat restarts are not tied to an input edge.
    localparam logic [CNT_WIDTH-1:0] LONG_TC = CNT_WIDTH'(LONG_TICKS - 2);
    localparam logic [CNT_WIDTH-1:0] DBL_TC  = CNT_WIDTH'(DBL_TICKS - 2);
    localparam logic [CNT_WIDTH-1:0] REP_TC  = CNT_WIDTH'(REPEAT_TICKS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HELD,
        S_LHELD,
        S_WAIT2,
        S_HELD2
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 short_d, double_d, long_d, repeat_d, held_d;
    logic                 dn, up;

    // A simultaneous press and release is a glitch and is treated as neither.
    assign dn = down_i & ~up_i;
    assign up = up_i & ~down_i;

    // State, counter and all outputs are registered together.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            short_o  <= 1'b0;
            double_o <= 1'b0;
            long_o   <= 1'b0;
            repeat_o <= 1'b0;
            held_o   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            short_o  <= short_d;
            double_o <= double_d;
            long_o   <= long_d;
            repeat_o <= repeat_d;
            held_o   <= held_d;
        end
    end

    // Next-state, counter and pulse decode; release/press beats terminal count.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + 1'b1;
        short_d  = 1'b0;
        double_d = 1'b0;
        long_d   = 1'b0;
        repeat_d = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (dn) state_d = S_HELD;
            end
            S_HELD: begin
                if (up) begin
                    state_d = S_WAIT2;
                    cnt_d   = '0;
                end else if (cnt_q == LONG_TC) begin
                    long_d  = 1'b1;
                    state_d = S_LHELD;
                    cnt_d   = '0;
                end
            end
            S_LHELD: begin
                if (up) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == REP_TC) begin
                    repeat_d = 1'b1;
                    cnt_d    = '0;
                end
            end
            S_WAIT2: begin
                if (dn) begin
                    state_d = S_HELD2;
                    cnt_d   = '0;
                end else if (cnt_q == DBL_TC) begin
                    short_d = 1'b1;
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            end
            S_HELD2: begin
                if (up) begin
                    double_d = 1'b1;
                    state_d  = S_IDLE;
                    cnt_d    = '0;
                end else if (cnt_q == LONG_TC) begin
                    short_d = 1'b1;
                    long_d  = 1'b1;
                    state_d = S_LHELD;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
        held_d = (state_d == S_HELD) || (state_d == S_LHELD) || (state_d == S_HELD2);
    end

endmodule

// File: tb/tb_button_press_decoder.sv
// Scoreboard bench for button_press_decoder: scenarios push expected pulse and
// held_o values keyed by absolute cycle; a negedge monitor pops and compares.
module tb_button_press_decoder;

    logic clk_i = 1'b0;
    logic rst_ni = 1'b0;
    logic down_i = 1'b0;
    logic up_i = 1'b0;
    logic short_o, double_o, long_o, repeat_o, held_o;

    button_press_decoder #(
        .CNT_WIDTH   (8),
        .LONG_TICKS  (8),
        .REPEAT_TICKS(4),
        .DBL_TICKS   (6)
    ) dut (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .down_i  (down_i),
        .up_i    (up_i),
        .short_o (short_o),
        .double_o(double_o),
        .long_o  (long_o),
        .repeat_o(repeat_o),
        .held_o  (held_o)
    );

    always #5 clk_i = ~clk_i;

    // pulse mask bits: {short, double, long, repeat}
    localparam logic [3:0] M_SHORT  = 4'b1000;
    localparam logic [3:0] M_DOUBLE = 4'b0100;
    localparam logic [3:0] M_LONG   = 4'b0010;
    localparam logic [3:0] M_REP    = 4'b0001;

    typedef struct { int cyc; logic [3:0] m; } pev_t;
    typedef struct { int cyc; logic v; } hev_t;

    pev_t pq[$];
    hev_t hq[$];
    int   abs_cyc = 0;
    int   base = 0;
    int   tests = 0;
    int   fails = 0;

    always @(posedge clk_i) abs_cyc <= abs_cyc + 1;

    task automatic exp_pulse(input int rel, input logic [3:0] m);
        pev_t e;
        e.cyc = base + rel;
        e.m   = m;
        pq.push_back(e);
    endtask

    task automatic exp_held(input int rel, input logic v);
        hev_t e;
        e.cyc = base + rel;
        e.v   = v;
        hq.push_back(e);
    endtask

    task automatic check(input string name, input logic [4:0] got, input logic [4:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %b want %b (cycle %0d)", name, got, want, abs_cyc);
        end
    endtask

    // Monitor: compares outputs against the scoreboard queues each negedge.
    always @(negedge clk_i) begin
        logic [3:0] p;
        p = {short_o, double_o, long_o, repeat_o};
        if (rst_ni) begin
            while (pq.size() > 0 && pq[0].cyc < abs_cyc) begin
                tests++;
                fails++;
                $display("FAIL missed_pulse: got none want %b at cycle %0d", pq[0].m, pq[0].cyc);
                void'(pq.pop_front());
            end
            if (p != 4'b0000) begin
                tests++;
                if (pq.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_pulse: got %b want none at cycle %0d", p, abs_cyc);
                end else begin
                    if (pq[0].cyc != abs_cyc || pq[0].m !== p) begin
                        fails++;
                        $display("FAIL pulse: got %b at cycle %0d want %b at cycle %0d",
                                 p, abs_cyc, pq[0].m, pq[0].cyc);
                    end
                    void'(pq.pop_front());
                end
            end
            while (hq.size() > 0 && hq[0].cyc <= abs_cyc) begin
                tests++;
                if (hq[0].cyc != abs_cyc || held_o !== hq[0].v) begin
                    fails++;
                    $display("FAIL held: got %b at cycle %0d want %b at cycle %0d",
                             held_o, abs_cyc, hq[0].v, hq[0].cyc);
                end
                void'(hq.pop_front());
            end
        end
    end

    // Drives one gesture: bit k of dm/um is down_i/up_i during relative cycle k.
    task automatic run_scn(input logic [63:0] dm, input logic [63:0] um, input int len);
        for (int k = 0; k < len; k++) begin
            down_i = dm[k];
            up_i   = um[k];
            @(negedge clk_i);
        end
        down_i = 1'b0;
        up_i   = 1'b0;
    endtask

    function automatic logic [63:0] bit_at(input int a);
        logic [63:0] v;
        v = '0;
        v[a] = 1'b1;
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        repeat (3) @(negedge clk_i);
        check("reset_outputs", {short_o, double_o, long_o, repeat_o, held_o}, 5'b00000);
        rst_ni = 1'b1;
        repeat (2) @(negedge clk_i);
        check("idle_outputs", {short_o, double_o, long_o, repeat_o, held_o}, 5'b00000);

        // short press
        base = abs_cyc;
        exp_held(0, 1'b0); exp_held(1, 1'b1); exp_held(3, 1'b1); exp_held(4, 1'b0);
        exp_pulse(9, M_SHORT);
        run_scn(bit_at(0), bit_at(3), 16);

        // double press
        base = abs_cyc;
        exp_held(6, 1'b1); exp_held(8, 1'b0);
        exp_pulse(8, M_DOUBLE);
        run_scn(bit_at(0) | bit_at(5), bit_at(2) | bit_at(7), 16);

        // long hold with repeats, release on a repeat cycle
        base = abs_cyc;
        exp_held(19, 1'b1); exp_held(20, 1'b0);
        exp_pulse(8, M_LONG); exp_pulse(12, M_REP); exp_pulse(16, M_REP);
        run_scn(bit_at(0), bit_at(19), 28);

        // release on the long terminal-count cycle
        base = abs_cyc;
        exp_held(8, 1'b0);
        exp_pulse(13, M_SHORT);
        run_scn(bit_at(0), bit_at(7), 20);

        // second press on the double-window timeout cycle
        base = abs_cyc;
        exp_held(8, 1'b1); exp_held(10, 1'b0);
        exp_pulse(10, M_DOUBLE);
        run_scn(bit_at(0) | bit_at(7), bit_at(2) | bit_at(9), 20);

        // short then long: short and long together, then a repeat
        base = abs_cyc;
        exp_held(18, 1'b1); exp_held(19, 1'b0);
        exp_pulse(13, M_SHORT | M_LONG); exp_pulse(17, M_REP);
        run_scn(bit_at(0) | bit_at(5), bit_at(2) | bit_at(18), 26);

        // glitch from IDLE
        base = abs_cyc;
        exp_held(1, 1'b0); exp_held(5, 1'b0);
        run_scn(bit_at(0), bit_at(0), 12);

        // glitch while held is ignored
        base = abs_cyc;
        exp_held(4, 1'b1); exp_held(6, 1'b0);
        exp_pulse(11, M_SHORT);
        run_scn(bit_at(0) | bit_at(3), bit_at(3) | bit_at(5), 18);

        // async reset during LHELD
        base = abs_cyc;
        exp_pulse(8, M_LONG); exp_held(9, 1'b1);
        run_scn(bit_at(0), 64'd0, 10);
        #1 rst_ni = 1'b0;
        #1 check("reset_mid_lheld", {short_o, double_o, long_o, repeat_o, held_o}, 5'b00000);
        repeat (3) @(negedge clk_i);
        rst_ni = 1'b1;
        base = abs_cyc;
        exp_held(1, 1'b0); exp_held(6, 1'b0);
        run_scn(64'd0, 64'd0, 24);

        repeat (2) @(negedge clk_i);
        tests++;
        if (pq.size() != 0 || hq.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: got %0d/%0d left want 0/0", pq.size(), hq.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
